// File: rtl/servile_wb_xbar_pkg.sv
// Shared types and constants for the servile Wishbone crossbar decoder.
package servile_wb_xbar_pkg;

   // Transaction sequencer states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      ERR  = 2'd2,
      DONE = 2'd3
   } state_t;

   // Read data returned when an access is unmapped or times out
   localparam logic [31:0] DEFAULT_ERR_RDT = 32'hDEADBEEF;

   // Largest supported number of slave ports
   localparam int MAX_SLAVES = 8;

endpackage

// File: rtl/servile_wb_addr_dec.sv
// Combinational match/mask address decoder: one-hot slave select, lowest index wins.
module servile_wb_addr_dec #(
   parameter int                       NUM_SLAVES = 4,
   parameter logic [NUM_SLAVES*32-1:0] SLV_MATCH  = {32'hC0000000, 32'h80000000, 32'h40000000, 32'h00000000},
   parameter logic [NUM_SLAVES*32-1:0] SLV_MASK   = {4{32'hC0000000}}
) (
   input  logic [31:0]           i_adr,
   output logic [NUM_SLAVES-1:0] o_sel,
   output logic                  o_hit
);

   logic [NUM_SLAVES-1:0] raw_hit;

   // Every slave compares only the address bits its mask selects
   for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_match
      assign raw_hit[gi] = ((i_adr & SLV_MASK[gi*32 +: 32]) == SLV_MATCH[gi*32 +: 32]);
   end

   // Priority pick: scan downwards so the lowest matching index is written last
   always_comb begin
      o_sel = '0;
      for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
         if (raw_hit[i]) begin
            o_sel = NUM_SLAVES'(1) << i;
         end
      end
   end

   assign o_hit = |raw_hit;

endmodule

// File: rtl/servile_wb_xbar_dec.sv
// Routes one servile CPU Wishbone master to NUM_SLAVES slaves with registered
// handshake, a per-access timeout and a sticky error status for software.
module servile_wb_xbar_dec
   import servile_wb_xbar_pkg::*;
#(
   parameter int                       NUM_SLAVES = 4,
   parameter logic [NUM_SLAVES*32-1:0] SLV_MATCH  = {32'hC0000000, 32'h80000000, 32'h40000000, 32'h00000000},
   parameter logic [NUM_SLAVES*32-1:0] SLV_MASK   = {4{32'hC0000000}},
   parameter int                       TIMEOUT    = 255,
   parameter logic [31:0]              ERR_RDT    = DEFAULT_ERR_RDT
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic [31:0]              i_wb_cpu_adr,
   input  logic [31:0]              i_wb_cpu_dat,
   input  logic [3:0]               i_wb_cpu_sel,
   input  logic                     i_wb_cpu_we,
   input  logic                     i_wb_cpu_stb,
   output logic [31:0]              o_wb_cpu_rdt,
   output logic                     o_wb_cpu_ack,
   output logic [31:0]              o_wb_slv_adr,
   output logic [31:0]              o_wb_slv_dat,
   output logic [3:0]               o_wb_slv_sel,
   output logic                     o_wb_slv_we,
   output logic [NUM_SLAVES-1:0]    o_wb_slv_stb,
   input  logic [NUM_SLAVES*32-1:0] i_wb_slv_rdt,
   input  logic [NUM_SLAVES-1:0]    i_wb_slv_ack,
   input  logic                     i_err_clr,
   output logic                     o_err,
   output logic [31:0]              o_err_adr,
   output logic                     o_err_tmo
);

   localparam int               CNT_W   = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TMO_CNT = CNT_W'(TIMEOUT);

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [31:0]           adr_q, adr_d;
   logic [31:0]           dat_q, dat_d;
   logic [3:0]            sel_q, sel_d;
   logic                  we_q, we_d;
   logic [NUM_SLAVES-1:0] stb_q, stb_d;
   logic [31:0]           rdt_q, rdt_d;
   logic                  ack_q, ack_d;
   logic                  tmo_q, tmo_d;
   logic                  err_q, err_d;
   logic [31:0]           err_adr_q, err_adr_d;
   logic                  err_tmo_q, err_tmo_d;

   logic [NUM_SLAVES-1:0] dec_sel;
   logic                  dec_hit;
   logic [31:0]           slv_rdt_mux;
   logic                  slv_ack_hit;
   logic [CNT_W-1:0]      cnt_inc;
   logic                  err_event;

   servile_wb_addr_dec #(
      .NUM_SLAVES (NUM_SLAVES),
      .SLV_MATCH  (SLV_MATCH),
      .SLV_MASK   (SLV_MASK)
   ) u_addr_dec (
      .i_adr (i_wb_cpu_adr),
      .o_sel (dec_sel),
      .o_hit (dec_hit)
   );

   // Read data of the strobed slave; the strobe itself doubles as the select
   always_comb begin
      slv_rdt_mux = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (stb_q[i]) begin
            slv_rdt_mux = slv_rdt_mux | i_wb_slv_rdt[i*32 +: 32];
         end
      end
   end

   // Acks from slaves that are not being strobed are masked off
   assign slv_ack_hit = |(i_wb_slv_ack & stb_q);
   assign cnt_inc     = cnt_q + CNT_W'(1);

   // Next-state: transaction sequencing, timeout counting and error status
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      adr_d     = adr_q;
      dat_d     = dat_q;
      sel_d     = sel_q;
      we_d      = we_q;
      stb_d     = stb_q;
      rdt_d     = rdt_q;
      ack_d     = 1'b0;
      tmo_d     = tmo_q;
      err_event = 1'b0;

      case (state_q)
         IDLE: begin
            if (i_wb_cpu_stb && !ack_q) begin
               adr_d = i_wb_cpu_adr;
               dat_d = i_wb_cpu_dat;
               sel_d = i_wb_cpu_sel;
               we_d  = i_wb_cpu_we;
               cnt_d = '0;
               if (dec_hit) begin
                  stb_d   = dec_sel;
                  state_d = BUSY;
               end else begin
                  tmo_d   = 1'b0;
                  state_d = ERR;
               end
            end
         end
         BUSY: begin
            // A slave ack in the same cycle the counter expires still wins
            cnt_d = cnt_inc;
            if (slv_ack_hit) begin
               ack_d   = 1'b1;
               rdt_d   = slv_rdt_mux;
               stb_d   = '0;
               state_d = DONE;
            end else if (cnt_inc == TMO_CNT) begin
               stb_d   = '0;
               tmo_d   = 1'b1;
               state_d = ERR;
            end
         end
         ERR: begin
            ack_d     = 1'b1;
            rdt_d     = ERR_RDT;
            err_event = 1'b1;
            state_d   = DONE;
         end
         DONE: begin
            // Gap cycle so the CPU can drop stb before the next accept
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Clear first, then a simultaneous new error overrides it
      err_d     = err_q;
      err_adr_d = err_adr_q;
      err_tmo_d = err_tmo_q;
      if (i_err_clr) begin
         err_d     = 1'b0;
         err_adr_d = '0;
         err_tmo_d = 1'b0;
      end
      if (err_event) begin
         err_d = 1'b1;
         if (!err_q || i_err_clr) begin
            err_adr_d = adr_q;
            err_tmo_d = tmo_q;
         end
      end
   end

   // State and output registers; reset aborts any access without acking
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         adr_q     <= '0;
         dat_q     <= '0;
         sel_q     <= '0;
         we_q      <= 1'b0;
         stb_q     <= '0;
         rdt_q     <= '0;
         ack_q     <= 1'b0;
         tmo_q     <= 1'b0;
         err_q     <= 1'b0;
         err_adr_q <= '0;
         err_tmo_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         adr_q     <= adr_d;
         dat_q     <= dat_d;
         sel_q     <= sel_d;
         we_q      <= we_d;
         stb_q     <= stb_d;
         rdt_q     <= rdt_d;
         ack_q     <= ack_d;
         tmo_q     <= tmo_d;
         err_q     <= err_d;
         err_adr_q <= err_adr_d;
         err_tmo_q <= err_tmo_d;
      end
   end

   assign o_wb_cpu_rdt = rdt_q;
   assign o_wb_cpu_ack = ack_q;
   assign o_wb_slv_adr = adr_q;
   assign o_wb_slv_dat = dat_q;
   assign o_wb_slv_sel = sel_q;
   assign o_wb_slv_we  = we_q;
   assign o_wb_slv_stb = stb_q;
   assign o_err        = err_q;
   assign o_err_adr    = err_adr_q;
   assign o_err_tmo    = err_tmo_q;

endmodule
